// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM state encoding,
// default buffer geometry and the CPU word width.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    CLR0  = 3'd1,
    BURST = 3'd2,
    CLR1  = 3'd3,
    RUN   = 3'd4
  } state_t;

  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_AW    = 5;
  localparam int CPU_W         = 32;

  function automatic logic [CPU_W-1:0] csum_add(input logic [CPU_W-1:0] acc,
                                                input logic [CPU_W-1:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Host word stream plus CPU-side load controls of the instruction loader.
// master = host/CPU side, slave = the loader itself.
interface instr_loader_if #(parameter int AW = 5);
  import instr_loader_pkg::*;

  logic [CPU_W-1:0] host_data;
  logic             host_valid;
  logic             host_last;
  logic             host_ready;
  logic             reload;
  logic             cpu_reset;
  logic             cpu_load;
  logic [CPU_W-1:0] cpu_instr;
  logic [AW:0]      word_count;
  logic             done;
  logic [CPU_W-1:0] checksum;

  modport master (
    output host_data, host_valid, host_last, reload,
    input  host_ready, cpu_reset, cpu_load, cpu_instr, word_count, done, checksum
  );

  modport slave (
    input  host_data, host_valid, host_last, reload,
    output host_ready, cpu_reset, cpu_load, cpu_instr, word_count, done, checksum
  );

endinterface

// File: rtl/instr_loader_buffer.sv
// Program buffer: DEPTH x CPU_W register array, synchronous write, registered
// read that returns zero when not enabled so the output can drive the CPU directly.
module loader_buffer
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [CPU_W-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [CPU_W-1:0] o_rdata
);

  logic [CPU_W-1:0] r_mem [DEPTH];
  logic [CPU_W-1:0] r_rdata;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_loader.sv
// Buffers a host program and replays it into the CPU instruction memory.
// Optional macro INSTR_LOADER_CHECKSUM_EN builds the additive checksum accumulator.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic        clk,
  input  logic        Reset,
  instr_loader_if.slave bus
);

  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [AW:0]      r_word_count;
  logic [AW-1:0]    r_rd_ptr;
  logic             r_cpu_reset;
  logic             r_cpu_load;
  logic             r_done;
  logic             w_host_ready;
  logic             w_xfer;
  logic             w_rd_en;
  logic [AW-1:0]    w_rd_addr;
  logic [AW:0]      w_last_idx;
  logic [CPU_W-1:0] w_rdata;

  assign w_host_ready = (r_state == FILL) && (r_word_count < DEPTH_W);
  assign w_xfer       = bus.host_valid && w_host_ready;
  assign w_last_idx   = r_word_count - (AW+1)'(1);

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL: begin
        if (w_xfer && (bus.host_last || (r_word_count == DEPTH_M1))) begin
          w_next_state = CLR0;
        end else if (r_word_count >= DEPTH_W) begin
          w_next_state = CLR0;
        end else begin
          w_next_state = FILL;
        end
      end
      CLR0:  w_next_state = BURST;
      BURST: begin
        if ({1'b0, r_rd_ptr} == w_last_idx) begin
          w_next_state = CLR1;
        end else begin
          w_next_state = BURST;
        end
      end
      CLR1:  w_next_state = RUN;
      RUN: begin
        if (bus.reload) begin
          w_next_state = FILL;
        end else begin
          w_next_state = RUN;
        end
      end
      default: w_next_state = FILL;
    endcase
  end

  // Read one word ahead so buffer data lands together with cpu_load.
  always_comb begin
    w_rd_en   = (w_next_state == BURST);
    w_rd_addr = '0;
    if (r_state == BURST) begin
      w_rd_addr = r_rd_ptr + AW'(1);
    end else begin
      w_rd_addr = '0;
    end
  end

  // State, counters and registered CPU controls.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= FILL;
      r_word_count <= '0;
      r_rd_ptr     <= '0;
      r_cpu_reset  <= 1'b1;
      r_cpu_load   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cpu_reset <= (w_next_state == FILL) || (w_next_state == CLR0) ||
                     (w_next_state == CLR1);
      r_cpu_load  <= (w_next_state == BURST);
      r_done      <= (w_next_state == RUN);
      if ((r_state == RUN) && bus.reload) begin
        r_word_count <= '0;
      end else if (w_xfer) begin
        r_word_count <= r_word_count + (AW+1)'(1);
      end else begin
        r_word_count <= r_word_count;
      end
      if (r_state == CLR0) begin
        r_rd_ptr <= '0;
      end else if (r_state == BURST) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  loader_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buffer (
    .clk     (clk),
    .Reset   (Reset),
    .i_we    (w_xfer),
    .i_waddr (r_word_count[AW-1:0]),
    .i_wdata (bus.host_data),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [CPU_W-1:0] r_checksum;

  // Modulo-2^32 sum of accepted words.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_checksum <= '0;
    end else if ((r_state == RUN) && bus.reload) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= csum_add(r_checksum, bus.host_data);
    end else begin
      r_checksum <= r_checksum;
    end
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = '0;
`endif

  assign bus.host_ready = w_host_ready;
  assign bus.cpu_reset  = r_cpu_reset;
  assign bus.cpu_load   = r_cpu_load;
  assign bus.cpu_instr  = w_rdata;
  assign bus.word_count = r_word_count;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: load, truncation, gapped valid, mid-burst
// reset and reload, with bench-computed expected words and checksums.
module tb_instr_loader;

  logic clk;
  logic Reset;
  int   n_vec;
  int   n_err;
  logic [31:0] exp_q[$];

  instr_loader_if #(.AW(5)) bus ();

  instr_loader #(.DEPTH(32), .AW(5)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_csum();
    logic [31:0] s;
    s = 32'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    foreach (exp_q[i]) s = s + exp_q[i];
`endif
    return s;
  endfunction

  // Present one word for one edge; expects it to be accepted.
  task automatic push(input logic [31:0] d, input logic last);
    logic acc;
    bus.host_data  = d;
    bus.host_valid = 1'b1;
    bus.host_last  = last;
    @(negedge clk);
    acc = bus.host_ready;
    @(posedge clk);
    #1;
    bus.host_valid = 1'b0;
    bus.host_last  = 1'b0;
    chk("accept", 32'(acc), 32'd1);
    exp_q.push_back(d);
  endtask

  // Entered one cycle after the last transfer (CLR0); follows through to RUN.
  task automatic watch_burst(input int n);
    chk("clr0_rst",   32'(bus.cpu_reset), 32'd1);
    chk("clr0_load",  32'(bus.cpu_load), 32'd0);
    chk("clr0_rdy",   32'(bus.host_ready), 32'd0);
    chk("clr0_instr", bus.cpu_instr, 32'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("bst_load",  32'(bus.cpu_load), 32'd1);
      chk("bst_rst",   32'(bus.cpu_reset), 32'd0);
      chk("bst_instr", bus.cpu_instr, exp_q[i]);
      chk("bst_done",  32'(bus.done), 32'd0);
      chk("bst_rdy",   32'(bus.host_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("clr1_rst",   32'(bus.cpu_reset), 32'd1);
    chk("clr1_load",  32'(bus.cpu_load), 32'd0);
    chk("clr1_instr", bus.cpu_instr, 32'd0);
    chk("clr1_done",  32'(bus.done), 32'd0);
    bus.reload = 1'b0;
    @(posedge clk);
    #1;
    chk("run_done",  32'(bus.done), 32'd1);
    chk("run_rst",   32'(bus.cpu_reset), 32'd0);
    chk("run_load",  32'(bus.cpu_load), 32'd0);
    chk("run_instr", bus.cpu_instr, 32'd0);
    chk("run_rdy",   32'(bus.host_ready), 32'd0);
    chk("run_wc",    32'(bus.word_count), 32'(n));
    chk("run_csum",  bus.checksum, exp_csum());
  endtask

  task automatic do_reload();
    bus.reload = 1'b1;
    @(posedge clk);
    #1;
    bus.reload = 1'b0;
    exp_q.delete();
    chk("rl_wc",   32'(bus.word_count), 32'd0);
    chk("rl_csum", bus.checksum, 32'd0);
    chk("rl_done", 32'(bus.done), 32'd0);
    chk("rl_rdy",  32'(bus.host_ready), 32'd1);
    chk("rl_rst",  32'(bus.cpu_reset), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1;
    bus.host_data  = 32'd0;
    bus.host_valid = 1'b0;
    bus.host_last  = 1'b0;
    bus.reload     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rst",   32'(bus.cpu_reset), 32'd1);
    chk("rst_load",  32'(bus.cpu_load), 32'd0);
    chk("rst_instr", bus.cpu_instr, 32'd0);
    chk("rst_rdy",   32'(bus.host_ready), 32'd1);
    chk("rst_wc",    32'(bus.word_count), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_csum",  bus.checksum, 32'd0);
    Reset = 1'b0;

    // Three-word program; reload held high through the burst must be ignored.
    exp_q.delete();
    push(32'h2001_0005, 1'b0);
    chk("s1_csum1", bus.checksum, exp_csum());
    push(32'h2002_0003, 1'b0);
    push(32'h0022_1820, 1'b1);
    bus.reload = 1'b1;
    watch_burst(3);
`ifdef INSTR_LOADER_CHECKSUM_EN
    chk("s1_csum_abs", bus.checksum, 32'h4025_1828);
`else
    chk("s1_csum_abs", bus.checksum, 32'h0000_0000);
`endif
    // Words offered in RUN are ignored.
    bus.host_valid = 1'b1;
    bus.host_data  = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    bus.host_valid = 1'b0;
    chk("run_ign_wc", 32'(bus.word_count), 32'd3);

    // DEPTH+4 words without host_last: truncation at 32.
    do_reload();
    for (int i = 0; i < 32; i++) begin
      push(32'h1000_0000 + 32'(i * 7), 1'b0);
    end
    bus.host_valid = 1'b1;
    bus.host_data  = 32'hDEAD_BEEF;
    watch_burst(32);
    bus.host_valid = 1'b0;

    // Gapped valid; reload pulsed in FILL must be ignored.
    do_reload();
    push(32'hA000_0001, 1'b0);
    bus.reload = 1'b1;
    @(posedge clk);
    #1;
    bus.reload = 1'b0;
    chk("fill_rl_wc", 32'(bus.word_count), 32'd1);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) begin
        bus.host_data = $urandom;
        @(posedge clk);
        #1;
      end
      chk("gap_wc", 32'(bus.word_count), 32'(i + 1));
      push(32'hA000_0010 + 32'(i), (i == 3) ? 1'b1 : 1'b0);
    end
    watch_burst(5);

    // Reset asserted during the second burst cycle.
    do_reload();
    push(32'h0000_0111, 1'b0);
    push(32'h0000_0222, 1'b0);
    push(32'h0000_0333, 1'b0);
    push(32'h0000_0444, 1'b1);
    @(posedge clk);
    #1;
    chk("mb_instr0", bus.cpu_instr, 32'h0000_0111);
    @(posedge clk);
    #1;
    chk("mb_load1",  32'(bus.cpu_load), 32'd1);
    chk("mb_instr1", bus.cpu_instr, 32'h0000_0222);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mb_load",  32'(bus.cpu_load), 32'd0);
    chk("mb_rst",   32'(bus.cpu_reset), 32'd1);
    chk("mb_wc",    32'(bus.word_count), 32'd0);
    chk("mb_rdy",   32'(bus.host_ready), 32'd1);
    chk("mb_instr", bus.cpu_instr, 32'd0);
    Reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mb_fill_rdy", 32'(bus.host_ready), 32'd1);
    chk("mb_fill_rst", 32'(bus.cpu_reset), 32'd1);
    chk("mb_fill_csum", bus.checksum, 32'd0);

    // Reach RUN, then reload a one-word program.
    exp_q.delete();
    push(32'h1111_1111, 1'b0);
    push(32'h2222_2222, 1'b1);
    watch_burst(2);
    do_reload();
    push(32'hAC01_0000, 1'b1);
    watch_burst(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
    chk("rl1_csum_abs", bus.checksum, 32'hAC01_0000);
`else
    chk("rl1_csum_abs", bus.checksum, 32'h0000_0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
